// File: rtl/fwd_hazard_unit_p.sv
// Forwarding and load-use hazard unit with an internal shadow pipeline
// of destination/write/load tags from EX downstream.
module fwd_hazard_unit_p #(
   parameter int REG_AW    = 5,
   parameter int FWD_DEPTH = 2,
   parameter int LOAD_LAT  = 1,
   parameter int FSW       = $clog2(FWD_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_wen,
   input  logic              id_load,
   input  logic              flush,
   input  logic              clr_cnt,
   output logic [FSW-1:0]    fwd_a,
   output logic [FSW-1:0]    fwd_b,
   output logic              stall,
   output logic [15:0]       stall_cnt
);

   if (1 + LOAD_LAT > FWD_DEPTH) begin : gBadCfg
      $error("fwd_hazard_unit_p: LOAD_LAT too large for FWD_DEPTH");
   end

   typedef struct packed {
      logic              v;
      logic              wen;
      logic              load;
      logic [REG_AW-1:0] dest;
   } ent_t;

   ent_t              e [FWD_DEPTH+1];
   logic              useRs;
   logic              useRt;
   logic [REG_AW-1:0] rs;
   logic [REG_AW-1:0] rt;
   logic [15:0]       cnt;
   logic              hazA;
   logic              hazB;
   logic              seenA;
   logic              seenB;

   function automatic logic isMatch(ent_t x, logic [REG_AW-1:0] r);
      return x.v && x.wen && (x.dest == r) && (r != '0);
   endfunction

   function automatic logic isReady(int k, logic ld);
      return (k >= 1) && (!ld || k >= 1 + LOAD_LAT);
   endfunction

   // Downstream entries always advance; only e[0] sees stall/flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= FWD_DEPTH; k++) e[k] <= '0;
         useRs <= 1'b0;
         useRt <= 1'b0;
         rs    <= '0;
         rt    <= '0;
      end else begin
         for (int k = 1; k <= FWD_DEPTH; k++) e[k] <= e[k-1];
         if (id_valid && !stall && !flush) begin
            e[0]  <= '{v: 1'b1, wen: id_wen, load: id_load, dest: id_dest};
            useRs <= id_use_rs;
            useRt <= id_use_rt;
            rs    <= id_rs;
            rt    <= id_rt;
         end else begin
            e[0]  <= '0;
            useRs <= 1'b0;
            useRt <= 1'b0;
         end
      end
   end

   // Descending scan so the youngest matching producer is the last write.
   always_comb begin
      fwd_a = '0;
      fwd_b = '0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
         if (useRs && isMatch(e[k], rs)) fwd_a = FSW'(k);
         if (useRt && isMatch(e[k], rt)) fwd_b = FSW'(k);
      end
   end

   always_comb begin
      hazA  = 1'b0;
      hazB  = 1'b0;
      seenA = 1'b0;
      seenB = 1'b0;
      for (int j = 0; j < FWD_DEPTH; j++) begin
         if (!seenA && isMatch(e[j], id_rs)) begin
            seenA = 1'b1;
            hazA  = !isReady(j + 1, e[j].load);
         end
         if (!seenB && isMatch(e[j], id_rt)) begin
            seenB = 1'b1;
            hazB  = !isReady(j + 1, e[j].load);
         end
      end
   end

   assign stall = id_valid && !flush &&
                  ((id_use_rs && hazA) || (id_use_rt && hazB));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr_cnt) begin
         cnt <= '0;
      end else if (stall && cnt != 16'hFFFF) begin
         cnt <= cnt + 16'd1;
      end
   end

   assign stall_cnt = cnt;

endmodule

// File: tb/tb_fwd_hazard_unit_p.sv
// Bench for fwd_hazard_unit_p: three configurations, directed scenarios
// plus random traffic against an issue-history reference model.
`timescale 1ns/1ps
module tb_fwd_hazard_unit_p;

   typedef struct packed {
      logic       v;
      logic       wen;
      logic       load;
      logic       ur;
      logic       ut;
      logic [4:0] dest;
      logic [4:0] rs;
      logic [4:0] rt;
   } ins_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   ins_t        idIn [3];
   logic        flushIn [3];
   logic        clrIn [3];
   logic [1:0]  fa0, fb0, fa1, fb1;
   logic [5:0]  fa2, fb2;
   logic        stallO [3];
   logic [15:0] cntO [3];

   int chk = 0;
   int err = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit_p #(.REG_AW(5), .FWD_DEPTH(2), .LOAD_LAT(1)) u0 (
      .clk(clk), .rst_n(rst_n), .id_valid(idIn[0].v),
      .id_rs(idIn[0].rs), .id_rt(idIn[0].rt),
      .id_use_rs(idIn[0].ur), .id_use_rt(idIn[0].ut),
      .id_dest(idIn[0].dest), .id_wen(idIn[0].wen),
      .id_load(idIn[0].load), .flush(flushIn[0]), .clr_cnt(clrIn[0]),
      .fwd_a(fa0), .fwd_b(fb0), .stall(stallO[0]), .stall_cnt(cntO[0]));

   fwd_hazard_unit_p #(.REG_AW(5), .FWD_DEPTH(3), .LOAD_LAT(2)) u1 (
      .clk(clk), .rst_n(rst_n), .id_valid(idIn[1].v),
      .id_rs(idIn[1].rs), .id_rt(idIn[1].rt),
      .id_use_rs(idIn[1].ur), .id_use_rt(idIn[1].ut),
      .id_dest(idIn[1].dest), .id_wen(idIn[1].wen),
      .id_load(idIn[1].load), .flush(flushIn[1]), .clr_cnt(clrIn[1]),
      .fwd_a(fa1), .fwd_b(fb1), .stall(stallO[1]), .stall_cnt(cntO[1]));

   fwd_hazard_unit_p #(.REG_AW(5), .FWD_DEPTH(32), .LOAD_LAT(31)) u2 (
      .clk(clk), .rst_n(rst_n), .id_valid(idIn[2].v),
      .id_rs(idIn[2].rs), .id_rt(idIn[2].rt),
      .id_use_rs(idIn[2].ur), .id_use_rt(idIn[2].ut),
      .id_dest(idIn[2].dest), .id_wen(idIn[2].wen),
      .id_load(idIn[2].load), .flush(flushIn[2]), .clr_cnt(clrIn[2]),
      .fwd_a(fa2), .fwd_b(fb2), .stall(stallO[2]), .stall_cnt(cntO[2]));

   function automatic int dep(int m);
      return (m == 0) ? 2 : (m == 1) ? 3 : 32;
   endfunction

   function automatic int lat(int m);
      return (m == 0) ? 1 : (m == 1) ? 2 : 31;
   endfunction

   function automatic logic [5:0] faOf(int m);
      return (m == 0) ? {4'b0, fa0} : (m == 1) ? {4'b0, fa1} : fa2;
   endfunction

   function automatic logic [5:0] fbOf(int m);
      return (m == 0) ? {4'b0, fb0} : (m == 1) ? {4'b0, fb1} : fb2;
   endfunction

   // Reference model: a log of what entered EX each cycle.  The
   // instruction that entered EX k cycles ago now sits at stage k.
   ins_t logH [3][64];
   int   wp;
   int   cntM [3];
   bit   stM [3];

   function automatic ins_t at(int m, int k);
      return logH[m][(wp - 1 - k) & 63];
   endfunction

   function automatic int youngest(int m, logic [4:0] r, int lo, int hi);
      for (int j = lo; j <= hi; j++) begin
         ins_t x = at(m, j);
         if (x.v && x.wen && x.dest == r && r != 5'd0) return j;
      end
      return -1;
   endfunction

   function automatic bit expStall(int m);
      if (!idIn[m].v || flushIn[m]) return 1'b0;
      for (int s = 0; s < 2; s++) begin
         logic       u = s ? idIn[m].ut : idIn[m].ur;
         logic [4:0] r = s ? idIn[m].rt : idIn[m].rs;
         if (u) begin
            int d = youngest(m, r, 0, dep(m) - 1);
            // Distance at EX entry is d+1; loads need 1+LOAD_LAT.
            if (d >= 0 && at(m, d).load && d + 1 < 1 + lat(m)) return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic int expFwd(int m, bit isB);
      ins_t       c = at(m, 0);
      logic       u = isB ? c.ut : c.ur;
      logic [4:0] r = isB ? c.rt : c.rs;
      int         d;
      if (!c.v || !u) return 0;
      d = youngest(m, r, 1, dep(m));
      return (d < 0) ? 0 : d;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 64; i++) logH[m][i] = '0;
            cntM[m] = 0;
         end
         wp = 0;
      end else begin
         for (int m = 0; m < 3; m++) stM[m] = expStall(m);
         for (int m = 0; m < 3; m++) begin
            logH[m][wp] = (idIn[m].v && !stM[m] && !flushIn[m]) ? idIn[m] : '0;
            if (clrIn[m]) cntM[m] = 0;
            else if (stM[m] && cntM[m] < 65535) cntM[m] = cntM[m] + 1;
         end
         wp = (wp + 1) & 63;
      end
   end

   localparam ins_t NOP = '0;

   function automatic ins_t mk(logic [4:0] d, logic [4:0] s, logic us,
                               logic [4:0] t, logic ut, logic ld);
      ins_t i;
      i.v = 1'b1; i.wen = 1'b1; i.load = ld;
      i.ur = us; i.ut = ut; i.dest = d; i.rs = s; i.rt = t;
      return i;
   endfunction

   task automatic issue(int m, ins_t i, logic fl = 1'b0, logic cl = 1'b0);
      @(negedge clk);
      for (int n = 0; n < 3; n++) begin
         idIn[n] = '0; flushIn[n] = 1'b0; clrIn[n] = 1'b0;
      end
      idIn[m] = i; flushIn[m] = fl; clrIn[m] = cl;
      #1;
   endtask

   task automatic drain(int m);
      for (int c = 0; c < dep(m) + 2; c++) issue(m, NOP);
   endtask

   task automatic test_reset();
      for (int n = 0; n < 3; n++) begin
         idIn[n] = mk(5'd4, 5'd4, 1'b1, 5'd4, 1'b1, 1'b1);
         flushIn[n] = 1'b0; clrIn[n] = 1'b0;
      end
      @(negedge clk); #1;
      for (int m = 0; m < 3; m++) begin
         chk++;
         if (stallO[m] !== 1'b0 || faOf(m) !== 6'd0 || fbOf(m) !== 6'd0 ||
             cntO[m] !== 16'd0) begin
            err++;
            $display("FAIL reset m=%0d got stall=%b fa=%0d fb=%0d cnt=%0d want all 0",
                     m, stallO[m], faOf(m), fbOf(m), cntO[m]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_ex_mem_fwd(int m);
      drain(m);
      issue(m, mk(5'd3, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0));
      chk++;
      if (stallO[m] !== 1'b0) begin
         err++; $display("FAIL exmem_stall1 m=%0d got %b want 0", m, stallO[m]);
      end
      issue(m, mk(5'd5, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0));
      chk++;
      if (stallO[m] !== 1'b0) begin
         err++; $display("FAIL exmem_stall2 m=%0d got %b want 0", m, stallO[m]);
      end
      issue(m, NOP);
      chk++;
      if (faOf(m) !== 6'd1 || fbOf(m) !== 6'd0) begin
         err++;
         $display("FAIL exmem_fwd m=%0d got fa=%0d fb=%0d want 1 0", m, faOf(m), fbOf(m));
      end
   endtask

   task automatic test_mem_wb_fwd(int m);
      drain(m);
      issue(m, mk(5'd3, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0));
      issue(m, NOP);
      issue(m, mk(5'd6, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0));
      issue(m, NOP);
      chk++;
      if (faOf(m) !== 6'd0 || fbOf(m) !== 6'd2) begin
         err++;
         $display("FAIL memwb_fwd m=%0d got fa=%0d fb=%0d want 0 2", m, faOf(m), fbOf(m));
      end
   endtask

   task automatic test_load_use();
      ins_t add = mk(5'd8, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0);
      drain(0);
      issue(0, mk(5'd4, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1));
      issue(0, add);
      chk++;
      if (stallO[0] !== 1'b1) begin
         err++; $display("FAIL lu_stall m=0 got %b want 1", stallO[0]);
      end
      issue(0, add);
      chk++;
      if (stallO[0] !== 1'b0 || cntO[0] !== 16'd1 || faOf(0) !== 6'd0) begin
         err++;
         $display("FAIL lu_release m=0 got stall=%b cnt=%0d fa=%0d want 0 1 0",
                  stallO[0], cntO[0], faOf(0));
      end
      issue(0, NOP);
      chk++;
      if (faOf(0) !== 6'd2 || fbOf(0) !== 6'd2 || cntO[0] !== 16'd1) begin
         err++;
         $display("FAIL lu_fwd m=0 got fa=%0d fb=%0d cnt=%0d want 2 2 1",
                  faOf(0), fbOf(0), cntO[0]);
      end
   endtask

   task automatic test_deep_load();
      ins_t add = mk(5'd9, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
      int   stalls = 0;
      drain(1);
      issue(1, mk(5'd4, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1));
      for (int c = 0; c < 3; c++) begin
         issue(1, add);
         if (stallO[1] === 1'b1) stalls++;
      end
      chk++;
      if (stalls != 2 || stallO[1] !== 1'b0) begin
         err++;
         $display("FAIL deep_stalls m=1 got %0d last=%b want 2 0", stalls, stallO[1]);
      end
      issue(1, NOP);
      chk++;
      if (faOf(1) !== 6'd3 || cntO[1] !== 16'd2) begin
         err++;
         $display("FAIL deep_fwd m=1 got fa=%0d cnt=%0d want 3 2", faOf(1), cntO[1]);
      end
   endtask

   task automatic test_youngest(int m);
      drain(m);
      issue(m, mk(5'd3, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0));
      issue(m, mk(5'd3, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0));
      issue(m, mk(5'd5, 5'd3, 1'b1, 5'd0, 1'b1, 1'b0));
      issue(m, NOP);
      chk++;
      if (faOf(m) !== 6'd1 || fbOf(m) !== 6'd0) begin
         err++;
         $display("FAIL youngest m=%0d got fa=%0d fb=%0d want 1 0", m, faOf(m), fbOf(m));
      end
   endtask

   task automatic test_reg0();
      drain(0);
      issue(0, mk(5'd0, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1));
      issue(0, mk(5'd8, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0));
      chk++;
      if (stallO[0] !== 1'b0) begin
         err++; $display("FAIL r0_stall m=0 got %b want 0", stallO[0]);
      end
      issue(0, NOP);
      chk++;
      if (faOf(0) !== 6'd0 || fbOf(0) !== 6'd0) begin
         err++; $display("FAIL r0_fwd m=0 got fa=%0d fb=%0d want 0 0", faOf(0), fbOf(0));
      end
   endtask

   task automatic test_flush();
      drain(0);
      issue(0, mk(5'd4, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1));
      issue(0, mk(5'd8, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0), 1'b1);
      chk++;
      if (stallO[0] !== 1'b0) begin
         err++; $display("FAIL flush_stall m=0 got %b want 0", stallO[0]);
      end
      issue(0, mk(5'd9, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0));
      issue(0, NOP);
      chk++;
      if (faOf(0) !== 6'd0) begin
         err++; $display("FAIL flush_bubble m=0 got fa=%0d want 0", faOf(0));
      end
   endtask

   task automatic test_reset_mid_stall();
      drain(0);
      issue(0, mk(5'd4, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1));
      issue(0, mk(5'd8, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0));
      chk++;
      if (stallO[0] !== 1'b1) begin
         err++; $display("FAIL rst_pre m=0 got stall=%b want 1", stallO[0]);
      end
      rst_n = 1'b0;
      #1;
      chk++;
      if (stallO[0] !== 1'b0 || faOf(0) !== 6'd0 || fbOf(0) !== 6'd0 ||
          cntO[0] !== 16'd0) begin
         err++;
         $display("FAIL rst_mid m=0 got stall=%b fa=%0d fb=%0d cnt=%0d want all 0",
                  stallO[0], faOf(0), fbOf(0), cntO[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(0, mk(5'd8, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0));
      chk++;
      if (stallO[0] !== 1'b0) begin
         err++; $display("FAIL rst_empty m=0 got stall=%b want 0", stallO[0]);
      end
   endtask

   task automatic test_random(int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         for (int m = 0; m < 3; m++) begin
            idIn[m].v    = ($urandom_range(0, 9) < 8);
            idIn[m].wen  = ($urandom_range(0, 9) < 8);
            idIn[m].load = ($urandom_range(0, 9) < 3);
            idIn[m].ur   = ($urandom_range(0, 9) < 7);
            idIn[m].ut   = ($urandom_range(0, 9) < 7);
            idIn[m].dest = 5'($urandom_range(0, 4));
            idIn[m].rs   = 5'($urandom_range(0, 4));
            idIn[m].rt   = 5'($urandom_range(0, 4));
            flushIn[m]   = ($urandom_range(0, 99) < 8);
            clrIn[m]     = ($urandom_range(0, 99) < 3);
         end
         #1;
         for (int m = 0; m < 3; m++) begin
            int k = int'(faOf(m));
            chk++;
            if (stallO[m] !== expStall(m) || faOf(m) !== 6'(expFwd(m, 1'b0)) ||
                fbOf(m) !== 6'(expFwd(m, 1'b1)) || cntO[m] !== 16'(cntM[m])) begin
               err++;
               $display("FAIL rand c=%0d m=%0d got st=%b fa=%0d fb=%0d cnt=%0d want %b %0d %0d %0d",
                        c, m, stallO[m], faOf(m), fbOf(m), cntO[m], expStall(m),
                        expFwd(m, 1'b0), expFwd(m, 1'b1), cntM[m]);
            end
            chk++;
            if (k != 0 && at(m, k).load && k < 1 + lat(m)) begin
               err++;
               $display("FAIL notready m=%0d got fa=%0d want a ready producer", m, k);
            end
         end
      end
   endtask

   task automatic test_saturate();
      bit found = 1'b0;
      issue(2, mk(5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1));
      repeat (68000) @(negedge clk);
      #1;
      chk++;
      if (cntO[2] !== 16'hFFFF) begin
         err++; $display("FAIL saturate m=2 got %h want ffff", cntO[2]);
      end
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk); #1;
         if (expStall(2)) found = 1'b1;
      end
      chk++;
      if (!found || stallO[2] !== 1'b1) begin
         err++; $display("FAIL clr_setup m=2 got stall=%b want 1", stallO[2]);
      end
      clrIn[2] = 1'b1;
      @(negedge clk); #1;
      clrIn[2] = 1'b0;
      chk++;
      if (cntO[2] !== 16'd0) begin
         err++; $display("FAIL clr_prio m=2 got %0d want 0", cntO[2]);
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_ex_mem_fwd(0);
      test_ex_mem_fwd(1);
      test_mem_wb_fwd(0);
      test_mem_wb_fwd(1);
      test_load_use();
      test_deep_load();
      test_youngest(0);
      test_youngest(1);
      test_reg0();
      test_flush();
      test_reset_mid_stall();
      test_random(800);
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit_p.md
Name: fwd_hazard_unit_p

Overview:
- Parametrised forwarding and load-use hazard unit for the 5-stage pipelined CPU.
- Keeps its own shadow pipeline of destination/write/load tags from EX downstream, so the datapath does not feed it tap wires.
- Produces per-operand forwarding selects for the EX stage, an IF/ID stall with ID/EX bubble insertion, and a saturating stall-cycle counter.
- Generalises fixed 2-source EX/MEM + MEM/WB forwarding to FWD_DEPTH sources and load latency LOAD_LAT.

Parameters:
- REG_AW, 5: register address width; register 0 is hard-wired zero.
- FWD_DEPTH, 2: number of downstream stage registers usable as forwarding sources (1 = EX/MEM, 2 = MEM/WB, ...).
- LOAD_LAT, 1: extra stages after EX before load data is forwardable. Legal only if 1+LOAD_LAT <= FWD_DEPTH; elaboration error otherwise.
- FSW, $clog2(FWD_DEPTH+1): forwarding select width (derived).

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  ID source registers.
- id_use_rs, id_use_rt  in  1  ID instruction reads rs / rt.
- id_dest  in  REG_AW  ID destination, after RegDst selection.
- id_wen  in  1  ID instruction writes a register.
- id_load  in  1  ID instruction is a load.
- flush  in  1  ID instruction is squashed (branch/jump).
- clr_cnt  in  1  synchronous clear of stall_cnt.
- fwd_a, fwd_b  out  FSW  EX operand source: 0 = ID/EX register value, k = stage-k result.
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- stall_cnt  out  16  saturating count of stall cycles.

Behaviour:
- Shadow entries e[0..FWD_DEPTH]: e[0] is EX, e[k] is the k-th register after EX.
  - Each entry holds {v, wen, load, dest}.
  - e[0] also holds {use_rs, rs, use_rt, rt} for forwarding.
- Every clock, e[k] <= e[k-1] for k >= 1, unconditionally; stall does not freeze downstream stages.
- e[0] load rule: e[0] <= ID fields if id_valid & !stall & !flush; otherwise e[0] <= bubble (v = 0, wen = 0).
- ready(k) = (k >= 1) & (!load | k >= 1+LOAD_LAT).
- match(k, r) = v & wen & dest == r & r != 0.
- Forwarding (combinational from registered state):
  - fwd_a = smallest k in 1..FWD_DEPTH with match(e[k], e[0].rs) & e[0].use_rs; else 0.
  - fwd_b is the same rule for rt.
  - Youngest producer always wins.
  - A matching producer that is not ready at its stage is impossible by construction; the bench asserts this never occurs.
- Stall (combinational):
  - For each used ID source r, find the youngest j in 0..FWD_DEPTH-1 with match(e[j], r).
  - Stall if that producer is not ready(j+1), i.e. not ready when the ID instruction reaches EX.
  - Producers beyond FWD_DEPTH rely on register-file write-before-read; no stall.
  - Gating: stall = 0 when !id_valid or flush; flush overrides stall.
- With LOAD_LAT = 1: load immediately followed by a consumer gives exactly 1 stall cycle. General case: LOAD_LAT stall cycles for back-to-back use.
- stall_cnt: +1 on each cycle with stall = 1, saturates at 16'hFFFF. clr_cnt has priority over increment in the same cycle.
- Reset (asynchronous, any time, including mid-stall):
  - All entries invalid, stall = 0, fwd_a = fwd_b = 0, stall_cnt = 0.
  - First post-reset cycle behaves as an empty pipe.

Test Plan:
- add r3 <- r1,r2; sub r5 <- r3,r4 back-to-back -> sub in EX: fwd_a = 1, fwd_b = 0, stall never high.
- add r3; nop; or r6 <- r7,r3 -> or in EX: fwd_b = 2, fwd_a = 0.
- Load-use, defaults: lw r4; add r8 <- r4,r4 -> stall = 1 for exactly 1 cycle; e[0] bubble; next cycle add in EX with fwd_a = fwd_b = 2; stall_cnt = 1.
- FWD_DEPTH = 3, LOAD_LAT = 2: lw r4; add uses r4 -> 2 stall cycles, then fwd_a = 3. Youngest wins: add r3; add r3; sub uses r3 -> fwd_a = 1.
- Register 0: lw r0; add uses r0 -> no stall, fwd_a = 0. Flush: lw r4 then flushed consumer -> stall = 0, bubble enters EX.
- Reset low during a stall -> outputs 0 immediately. Force 70000 stall cycles -> stall_cnt = FFFF; clr_cnt together with stall -> 0.
